// File: rtl/mem_pkg.sv
// Shared types and widths for the memory host path. The arbiter and the
// requesters both use these.
package mem_pkg;

  localparam int LINE_W = 512;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RSVD  = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  // A reserved op counts as no request.
  function automatic logic op_valid(mem_op_t op);
    return (op == READ) || (op == WRITE);
  endfunction

endpackage

// File: rtl/mem_host_arbiter.sv
// Round-robin arbiter that shares the mem_ctrl host port between fetch and the
// memory stage. It also has a sticky watchdog for transfers that never complete.
module mem_host_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_tx_done,
  output logic              i_rd_valid,
  input  logic [1:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_tx_done,
  output logic              d_rd_valid,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_tx_done,
  input  logic              mem_rd_valid,
  output logic              grant_d,
  output logic              err
);

  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic             last_d_r;
  logic [CNT_W-1:0] wdog_r;
  logic [CNT_W-1:0] wdog_inc_s;
  logic             err_r;
  logic             i_req_s;
  logic             d_req_s;

  assign i_req_s    = op_valid(mem_op_t'(i_op));
  assign d_req_s    = op_valid(mem_op_t'(d_op));
  assign wdog_inc_s = (&wdog_r) ? wdog_r : wdog_r + CNT_W'(1);
  assign err        = err_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: on a tie, the side that was not served last wins. A granted
  // side keeps the port until mem_ctrl completes, even if its op drops.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          state_nxt_s = last_d_r ? BUSY_I : BUSY_D;
        end else if (d_req_s) begin
          state_nxt_s = BUSY_D;
        end else if (i_req_s) begin
          state_nxt_s = BUSY_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_tx_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Remember which side finished last, for tie-breaking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_r <= 1'b0;
    end else if ((state_r != IDLE) && mem_tx_done) begin
      last_d_r <= (state_r == BUSY_D);
    end
  end

  // Watchdog: cleared while idle, so each grant starts counting from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= {CNT_W{1'b0}};
      err_r  <= 1'b0;
    end else if (state_r == IDLE) begin
      wdog_r <= {CNT_W{1'b0}};
    end else begin
      wdog_r <= wdog_inc_s;
      if (wdog_inc_s == TMO_C) begin
        err_r <= 1'b1;
      end
    end
  end

  // Output steering: only the granted side is connected to mem_ctrl
  always_comb begin
    mem_op     = 2'b00;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {LINE_W{1'b0}};
    i_rdata    = {LINE_W{1'b0}};
    i_tx_done  = 1'b0;
    i_rd_valid = 1'b0;
    d_rdata    = {LINE_W{1'b0}};
    d_tx_done  = 1'b0;
    d_rd_valid = 1'b0;
    grant_d    = 1'b0;
    case (state_r)
      BUSY_I: begin
        mem_op     = i_op;
        mem_addr   = i_addr;
        mem_wdata  = i_wdata;
        i_rdata    = mem_rdata;
        i_tx_done  = mem_tx_done;
        i_rd_valid = mem_rd_valid;
      end
      BUSY_D: begin
        mem_op     = d_op;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
        d_rdata    = mem_rdata;
        d_tx_done  = mem_tx_done;
        d_rd_valid = mem_rd_valid;
        grant_d    = 1'b1;
      end
      default: grant_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_host_arbiter.sv
// Bench for mem_host_arbiter: a set of directed scenarios followed by random
// traffic, each checked every cycle against an ownership model.
module tb_mem_host_arbiter;

  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   i_op, d_op, mem_op;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic [511:0] i_wdata, d_wdata, mem_wdata, i_rdata, d_rdata, mem_rdata;
  logic         i_tx_done, i_rd_valid, d_tx_done, d_rd_valid;
  logic         mem_tx_done, mem_rd_valid, grant_d, err;

  mem_host_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_op(i_op), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdata(i_rdata),
    .i_tx_done(i_tx_done), .i_rd_valid(i_rd_valid),
    .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_tx_done(d_tx_done), .d_rd_valid(d_rd_valid),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_tx_done(mem_tx_done), .mem_rd_valid(mem_rd_valid),
    .grant_d(grant_d), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: owner of the port (0 none, 1 instruction, 2 data)
  int own, m_cnt, n_vec, n_bad;
  bit m_last_d, m_err, m_new_grant, m_i_done, m_d_done;

  function automatic bit req_valid(logic [1:0] op);
    return (op == 2'd1) || (op == 2'd2);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; m_cnt = 0; m_last_d = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_all();
    chk("grant_d",    grant_d,    own == 2);
    chk("mem_op",     mem_op,     own == 1 ? i_op    : own == 2 ? d_op    : 2'd0);
    chk("mem_addr",   mem_addr,   own == 1 ? i_addr  : own == 2 ? d_addr  : 32'd0);
    chk("mem_wdata",  mem_wdata,  own == 1 ? i_wdata : own == 2 ? d_wdata : 512'd0);
    chk("i_rdata",    i_rdata,    own == 1 ? mem_rdata : 512'd0);
    chk("d_rdata",    d_rdata,    own == 2 ? mem_rdata : 512'd0);
    chk("i_tx_done",  i_tx_done,  own == 1 && mem_tx_done);
    chk("d_tx_done",  d_tx_done,  own == 2 && mem_tx_done);
    chk("i_rd_valid", i_rd_valid, own == 1 && mem_rd_valid);
    chk("d_rd_valid", d_rd_valid, own == 2 && mem_rd_valid);
    chk("err",        err,        m_err);
  endtask

  // Advance the model across one rising edge using the inputs held at that edge
  task automatic tick_edge();
    bit vi, vd;
    vi = req_valid(i_op);
    vd = req_valid(d_op);
    m_i_done = (own == 1) && mem_tx_done;
    m_d_done = (own == 2) && mem_tx_done;
    m_new_grant = 1'b0;
    if (rst_n) begin
      if (own == 0) begin
        if (vi && vd) own = m_last_d ? 1 : 2;
        else if (vd)  own = 2;
        else if (vi)  own = 1;
        if (own != 0) begin
          m_cnt = 0;
          m_new_grant = 1'b1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == TIMEOUT) m_err = 1'b1;
        if (mem_tx_done) begin
          m_last_d = (own == 2);
          own = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc();
    tick_edge();
    sample();
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    i_op = 2'd0; i_addr = 32'd0; i_wdata = 512'd0;
    d_op = 2'd0; d_addr = 32'd0; d_wdata = 512'd0;
    mem_rdata = 512'd0; mem_tx_done = 1'b0; mem_rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse completion for one cycle on the current owner, then step past it
  task automatic complete(input logic [511:0] data);
    mem_rdata = data;
    mem_tx_done = 1'b1;
    mem_rd_valid = (mem_op == 2'd1);
    settle();
    cyc();
    mem_tx_done = 1'b0;
    mem_rd_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] pat;
    int rem, err_at;
    logic exp_seq [6];
    logic got_seq [$];
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single read from the instruction side, completing 5 cycles after grant
    i_op = 2'd1; i_addr = 32'h0600_2000;
    cyc();
    chk("single_mem_op", mem_op, 2'd1);
    chk("single_mem_addr", mem_addr, 32'h0600_2000);
    repeat (4) cyc();
    pat = {16{$urandom()}};
    mem_rdata = pat; mem_tx_done = 1'b1; mem_rd_valid = 1'b1;
    settle();
    chk("single_i_rdata", i_rdata, pat);
    chk("single_i_done", i_tx_done, 1'b1);
    chk("single_d_done", d_tx_done, 1'b0);
    cyc();
    i_op = 2'd0; mem_tx_done = 1'b0; mem_rd_valid = 1'b0;
    cyc();
    chk("single_idle", mem_op, 2'd0);

    // Tie straight after reset goes to the data side, then the instruction side
    do_reset();
    i_op = 2'd1; i_addr = $urandom();
    d_op = 2'd2; d_addr = 32'h100; d_wdata = {16{$urandom()}};
    cyc();
    chk("tie_d_first", grant_d, 1'b1);
    chk("tie_d_wdata", mem_wdata, d_wdata);
    cyc();
    complete({16{$urandom()}});
    d_op = 2'd0;
    chk("tie_gap_idle", mem_op, 2'd0);
    cyc();
    chk("tie_then_i", grant_d, 1'b0);
    chk("tie_then_i_op", mem_op, 2'd1);
    complete({16{$urandom()}});
    i_op = 2'd0;

    // Sustained load from both sides alternates, starting with data
    do_reset();
    i_op = 2'd1; d_op = 2'd2; i_addr = $urandom(); d_addr = $urandom();
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      cyc();
      got_seq.push_back(grant_d);
      cyc();
      complete({16{$urandom()}});
    end
    for (int t = 0; t < 6; t++) chk("fair_seq", got_seq[t], exp_seq[t]);
    i_op = 2'd0; d_op = 2'd0;
    cyc();

    // Stray completion pulses while idle are not forwarded
    for (int t = 0; t < 4; t++) begin
      mem_tx_done = 1'b1; mem_rd_valid = 1'b1; mem_rdata = {16{$urandom()}};
      settle();
      cyc();
      chk("stray_idle", mem_op, 2'd0);
    end
    mem_tx_done = 1'b0; mem_rd_valid = 1'b0;
    cyc();

    // Randomized traffic from both requesters and a responding mem_ctrl
    rem = 0;
    for (int n = 0; n < 400; n++) begin
      tick_edge();
      if (m_i_done || !req_valid(i_op)) begin
        i_op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        i_addr = $urandom(); i_wdata = {16{$urandom()}};
      end
      if (m_d_done || !req_valid(d_op)) begin
        d_op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        d_addr = $urandom(); d_wdata = {16{$urandom()}};
      end
      mem_rdata = {16{$urandom()}};
      if (own != 0) begin
        rem = m_new_grant ? $urandom_range(1, 5) : rem - 1;
        mem_tx_done = (rem == 1);
        mem_rd_valid = (rem == 1) && (mem_op == 2'd1);
      end else begin
        mem_tx_done = ($urandom_range(0, 3) == 0);
        mem_rd_valid = $urandom_range(0, 1);
      end
      sample();
    end

    // Watchdog: err rises exactly TIMEOUT edges after the grant and stays set
    do_reset();
    d_op = 2'd1; d_addr = $urandom();
    cyc();
    err_at = -1;
    for (int j = 1; j <= TIMEOUT + 3; j++) begin
      cyc();
      if (err && err_at < 0) err_at = j;
    end
    chk("wdog_err_edge", err_at, TIMEOUT);
    chk("wdog_grant_held", grant_d, 1'b1);
    complete({16{$urandom()}});
    d_op = 2'd0;
    cyc();
    chk("wdog_err_sticky", err, 1'b1);

    // Asynchronous reset in the middle of an instruction-side transfer
    i_op = 2'd1; i_addr = $urandom();
    cyc();
    cyc();
    mem_tx_done = 1'b1;
    settle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mem_op", mem_op, 2'd0);
    chk("rst_i_done", i_tx_done, 1'b0);
    chk("rst_err", err, 1'b0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    i_op = 2'd2; d_op = 2'd1;
    cyc();
    chk("rst_tie_d", grant_d, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
